// File: rtl/rx_block_sync_pkg.sv
// Shared definitions for the 64b/66b receive path: block-sync FSM states
// and the two legal sync-header encodings, reused by descrambler and TX.
package rx_block_sync_pkg;

  typedef enum logic [1:0] {
    HUNT      = 2'd0,
    SLIP_WAIT = 2'd1,
    LOCKED    = 2'd2
  } sync_state_t;

  localparam logic [1:0] SYNC_DATA = 2'b01;
  localparam logic [1:0] SYNC_CTRL = 2'b10;

  // A header is legal only when its two bits differ.
  function automatic logic isValidHeader(input logic [1:0] hdr);
    return (hdr == SYNC_DATA) || (hdr == SYNC_CTRL);
  endfunction

endpackage

// File: rtl/rx_block_sync.sv
// 64b/66b block synchroniser: hunts for sync-header alignment by asking the
// gearbox to slip one bit at a time, declares lock after a full window of
// good headers, and drops lock when too many bad headers appear in a window.
module rx_block_sync
  import rx_block_sync_pkg::*;
#(
  parameter int RX_DATA_WIDTH      = 64,
  parameter int SH_CNT_MAX         = 64,
  parameter int SH_INVALID_CNT_MAX = 16,
  parameter int SLIP_WAIT_CYCLES   = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [RX_DATA_WIDTH+1:0] data_in,
  input  logic                     data_in_valid,
  output logic                     slip,
  output logic                     block_lock,
  output logic [RX_DATA_WIDTH+1:0] data_out,
  output logic                     data_out_valid
);

  localparam int SH_CNT_W   = $clog2(SH_CNT_MAX + 1);
  localparam int INV_CNT_W  = $clog2(SH_INVALID_CNT_MAX + 1);
  localparam int WAIT_CNT_W = $clog2(SLIP_WAIT_CYCLES + 1);

  localparam logic [SH_CNT_W-1:0]   SH_CNT_LAST  = SH_CNT_W'(SH_CNT_MAX - 1);
  localparam logic [INV_CNT_W-1:0]  INV_CNT_LAST = INV_CNT_W'(SH_INVALID_CNT_MAX - 1);
  localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD    = WAIT_CNT_W'(SLIP_WAIT_CYCLES);

  sync_state_t              state_q, state_d;
  logic [SH_CNT_W-1:0]      shCnt_q, shCnt_d;
  logic [INV_CNT_W-1:0]     shInvalidCnt_q, shInvalidCnt_d;
  logic [WAIT_CNT_W-1:0]    waitCnt_q, waitCnt_d;
  logic                     slip_q, slip_d;
  logic                     blockLock_q, blockLock_d;
  logic [RX_DATA_WIDTH+1:0] dataOut_q;
  logic                     dataOutValid_q;
  logic                     headerOk;

  assign headerOk = isValidHeader(data_in[RX_DATA_WIDTH+1:RX_DATA_WIDTH]);

  // Next-state logic: header evaluation, window/error counting and slip requests.
  always_comb begin
    state_d        = state_q;
    shCnt_d        = shCnt_q;
    shInvalidCnt_d = shInvalidCnt_q;
    waitCnt_d      = waitCnt_q;
    slip_d         = 1'b0;
    blockLock_d    = blockLock_q;

    case (state_q)
      HUNT: begin
        if (data_in_valid) begin
          if (!headerOk) begin
            slip_d    = 1'b1;
            shCnt_d   = '0;
            waitCnt_d = WAIT_LOAD;
            state_d   = SLIP_WAIT;
          end else if (shCnt_q == SH_CNT_LAST) begin
            state_d        = LOCKED;
            blockLock_d    = 1'b1;
            shCnt_d        = '0;
            shInvalidCnt_d = '0;
          end else begin
            shCnt_d = shCnt_q + SH_CNT_W'(1);
          end
        end
      end

      SLIP_WAIT: begin
        // The gearbox needs time to settle after a slip, so headers are ignored.
        if (waitCnt_q <= WAIT_CNT_W'(1)) begin
          waitCnt_d = '0;
          state_d   = HUNT;
        end else begin
          waitCnt_d = waitCnt_q - WAIT_CNT_W'(1);
        end
      end

      LOCKED: begin
        if (data_in_valid) begin
          // Reaching the error limit wins over a coincident window end.
          if (!headerOk && (shInvalidCnt_q == INV_CNT_LAST)) begin
            blockLock_d    = 1'b0;
            slip_d         = 1'b1;
            shCnt_d        = '0;
            shInvalidCnt_d = '0;
            waitCnt_d      = WAIT_LOAD;
            state_d        = SLIP_WAIT;
          end else if (shCnt_q == SH_CNT_LAST) begin
            shCnt_d        = '0;
            shInvalidCnt_d = '0;
          end else begin
            shCnt_d = shCnt_q + SH_CNT_W'(1);
            if (!headerOk) begin
              shInvalidCnt_d = shInvalidCnt_q + INV_CNT_W'(1);
            end
          end
        end
      end

      default: begin
        state_d     = HUNT;
        blockLock_d = 1'b0;
      end
    endcase
  end

  // State, counter and output registers, cleared by synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= HUNT;
      shCnt_q        <= '0;
      shInvalidCnt_q <= '0;
      waitCnt_q      <= '0;
      slip_q         <= 1'b0;
      blockLock_q    <= 1'b0;
      dataOut_q      <= '0;
      dataOutValid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      shCnt_q        <= shCnt_d;
      shInvalidCnt_q <= shInvalidCnt_d;
      waitCnt_q      <= waitCnt_d;
      slip_q         <= slip_d;
      blockLock_q    <= blockLock_d;
      if (data_in_valid) begin
        dataOut_q <= data_in;
      end
      dataOutValid_q <= data_in_valid & blockLock_q;
    end
  end

  assign slip           = slip_q;
  assign block_lock     = blockLock_q;
  assign data_out       = dataOut_q;
  assign data_out_valid = dataOutValid_q;

endmodule

// File: doc/rx_block_sync.md
RX_BLOCK_SYNC -- requirements
Module: rx_block_sync

Interface
REQ-001 The block SHALL have parameter RX_DATA_WIDTH, default 64, meaning the payload width per block, excluding the 2-bit sync header.
REQ-002 The block SHALL have parameter SH_CNT_MAX, default 64, meaning the number of headers per test window and the number of consecutive valid headers needed to lock.
REQ-003 The block SHALL have parameter SH_INVALID_CNT_MAX, default 16, meaning the number of invalid headers within one window that causes loss of lock.
REQ-004 The block SHALL have parameter SLIP_WAIT_CYCLES, default 32, meaning the number of clk cycles headers are ignored after a slip.
REQ-005 The block SHALL have port clk, input, width 1, meaning the RX user clock; all logic is on its rising edge.
REQ-006 The block SHALL have port rst, input, width 1, meaning a synchronous, active-high reset.
REQ-007 The block SHALL have port data_in, input, width RX_DATA_WIDTH+2, meaning the gearbox block; bits [RX_DATA_WIDTH+1:RX_DATA_WIDTH] are the sync header.
REQ-008 The block SHALL have port data_in_valid, input, width 1, meaning data_in holds a complete block this cycle.
REQ-009 The block SHALL have port slip, output, width 1, meaning a one-cycle pulse asking the gearbox to shift alignment by one bit.
REQ-010 The block SHALL have port block_lock, output, width 1, meaning header alignment is achieved.
REQ-011 The block SHALL have port data_out, output, width RX_DATA_WIDTH+2, meaning the registered copy of data_in, with the header in the same bit positions; it feeds the descrambler.
REQ-012 The block SHALL have port data_out_valid, output, width 1, meaning data_out is a locked, valid block; it drives the descrambler enable.

Function
REQ-013 A header SHALL be valid iff it equals 2'b01 (data) or 2'b10 (control); 2'b00 and 2'b11 are invalid.
REQ-014 Only cycles with data_in_valid=1 SHALL be evaluated; all other cycles leave counters unchanged.
REQ-015 The FSM SHALL have states HUNT, SLIP_WAIT and LOCKED; the reset state is HUNT.
REQ-016 In HUNT, a valid header SHALL increment sh_cnt; on reaching SH_CNT_MAX, the FSM goes to LOCKED, block_lock=1 and both counters clear.
REQ-017 In HUNT, an invalid header SHALL pulse slip, clear sh_cnt, load the wait counter with SLIP_WAIT_CYCLES, and go to SLIP_WAIT.
REQ-018 SLIP_WAIT SHALL ignore data_in_valid, decrement the wait counter every clk cycle, and return to HUNT after SLIP_WAIT_CYCLES cycles.
REQ-019 In LOCKED, every evaluated header SHALL increment sh_cnt, and every invalid header SHALL also increment sh_invalid_cnt.
REQ-020 In LOCKED, when sh_invalid_cnt reaches SH_INVALID_CNT_MAX, the block SHALL clear block_lock, pulse slip, clear counters, and go to SLIP_WAIT.
REQ-021 In LOCKED, when sh_cnt reaches SH_CNT_MAX with sh_invalid_cnt below the limit, both counters SHALL clear and the FSM stays LOCKED (window restart).
REQ-022 If the window end and the invalid limit occur on the same header, loss of lock SHALL take priority.
REQ-023 slip and block_lock SHALL be registered, changing on the clk edge after the deciding header is sampled.
REQ-024 slip SHALL be high for exactly one cycle per slip event and never while block_lock=1.
REQ-025 data_out SHALL be loaded whenever data_in_valid=1, with latency 1 cycle.
REQ-026 data_out_valid SHALL equal the registered value of (data_in_valid AND the lock state in effect for that header).
REQ-027 Counter widths SHALL be $clog2(max+1); counters never wrap, because they clear at their limit.

Reset
REQ-028 rst=1 SHALL force state=HUNT, slip=0, block_lock=0, data_out=0, data_out_valid=0 and all counters to 0 on the next clk edge.
REQ-029 rst asserted mid-SLIP_WAIT or mid-LOCKED SHALL abandon the operation with no slip pulse, and outputs SHALL hold their reset values while rst is high.

Structure
REQ-030 A shared package SHALL hold the FSM state enum and the header constants SYNC_DATA=2'b01 and SYNC_CTRL=2'b10, for reuse by the descrambler and TX side.
REQ-031 The block SHALL be a single module with no sub-module.

Verification
REQ-032 Scenario "acquire": 64 consecutive valid headers (alternating 01/10) -> block_lock=1 one cycle after the 64th, with no slip.
REQ-033 Scenario "hunt slip": after 10 valid headers, header 2'b11 -> slip high exactly 1 cycle, then 32 cycles of headers ignored, then counting restarts from 0.
REQ-034 Scenario "tolerated errors": while locked, 15 invalid headers in a 64-header window -> block_lock stays 1, and the next window starts with counts cleared.
REQ-035 Scenario "loss of lock": while locked, 16 invalid headers within one window -> block_lock=0 and slip pulses on the same edge; the 16th invalid header arriving at header 64 also unlocks.
REQ-036 Scenario "gapped valid": data_in_valid high 1 cycle in 3 -> lock after 64 valid strobes (~192 cycles), and data_out_valid pulses only on the strobes.
REQ-037 Scenario "reset mid-lock": rst for 1 cycle while locked -> all outputs 0 next cycle, and 64 new valid headers are needed to relock.
